stress_freq_meter: RTL and testbench
====================================

// Module: stress_freq_meter
// PURPOSE
//   Front-end measurement stage of the stress sensor. Counts rising edges of the
//   stress-sensitive ring-oscillator output over a fixed gate window of system
//   clocks and hands the count downstream on a valid/ready interface.
//   Feeds the readout/serialiser logic in tt_um_stress_sensor.
// PARAMETERS
//   GATE_CYCLES  1024  gate window length in clk cycles (>=2)
//   CNT_W        16    width of edge counter / result
//   SYNC_STAGES  2     synchroniser depth for osc_in (>=2)
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous active-low reset
//   en         in   1      block enable; low forces IDLE
//   osc_in     in   1      oscillator output, asynchronous to clk
//   start      in   1      1-cycle request to begin a measurement
//   continuous in   1      1 = re-arm automatically after each transfer
//   ready      in   1      downstream accepts result
//   count_out  out  CNT_W  edge count of last completed window
//   valid      out  1      count_out/overflow hold a result
//   overflow   out  1      counter saturated during that window
//   busy       out  1      state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE; count_out=0, valid=0, overflow=0, busy=0; synchroniser,
//     edge-detect and gate counter flops cleared. Asserting rst_n low mid-window
//     aborts immediately; no partial result is ever presented.
//   Input path: osc_in -> SYNC_STAGES flops -> one delay flop; edge pulse =
//     sync_out & ~delayed. Pulse lags osc_in by SYNC_STAGES+1 clk; not
//     compensated. Valid for osc_in < clk/2 with high/low each >=1 clk period.
//   FSM (registered state, one clk per transition):
//     IDLE : start&en -> ARM. Otherwise stay.
//     ARM  : edge counter<=0, overflow flag<=0, gate counter<=0 -> GATE.
//     GATE : exactly GATE_CYCLES cycles. Each cycle with edge pulse: counter+1,
//            saturating at 2^CNT_W-1; increment attempted at max sets overflow.
//            On last gate cycle (incl. its pulse) -> HOLD; count_out/overflow
//            loaded from final counter value, valid<=1 on entry to HOLD.
//     HOLD : valid=1, count_out/overflow stable. valid&ready -> valid<=0 next
//            cycle; then continuous ? ARM : IDLE.
//   Latency: start sampled at cycle 0 -> ARM cycle 1 -> GATE cycles
//     2..GATE_CYCLES+1 -> valid high from cycle GATE_CYCLES+2.
//   Handshake: valid never drops without ready (except en low / reset);
//     count_out changes only on entry to HOLD. ready ignored when valid=0.
//   start while busy: ignored (no queueing). start&~en: ignored.
//   continuous sampled in HOLD at transfer cycle only; clearing it mid-window
//     lets current window finish, then returns to IDLE.
//   en low in any state: next cycle state=IDLE, valid=0, overflow=0; count_out
//     keeps last value. Counters cleared on next ARM.
//   Gate counter width = clog2(GATE_CYCLES); wraps only via ARM reload.
// TESTING
//   GATE_CYCLES=64, osc_in period 4 clk, start -> valid at cycle 66, count_out=16 (+-1), overflow=0.
//   CNT_W=4, osc period 2 clk, GATE_CYCLES=64 -> count_out=15, overflow=1.
//   Hold ready=0 for 10 cycles after valid -> valid/count_out stable; ready=1 one cycle -> valid=0 next, busy=0.
//   continuous=1, ready tied 1, osc period 8 -> back-to-back results of 8 every GATE_CYCLES+2 cycles.
//   rst_n low at gate cycle 20 then release -> outputs 0, IDLE; start ignored mid-window, en low mid-window -> IDLE, no valid.
//   osc_in held constant, start -> count_out=0, overflow=0, valid after GATE_CYCLES+2.

Source files
------------

// File: rtl/stress_freq_meter.sv
// Ring-oscillator edge counter: synchronises osc_in, counts rising edges over a fixed
// window of clk cycles and presents the result on a valid/ready interface.
module stress_freq_meter #(
    parameter int unsigned GATE_CYCLES = 1024,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             osc_in,
    input  logic             start,
    input  logic             continuous,
    input  logic             ready,
    output logic [CNT_W-1:0] count_out,
    output logic             valid,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [1:0] {StIdle, StArm, StGate, StHold} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;
    logic                   edge_pulse;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_next;
    logic                   ovf_q, ovf_d, ovf_next;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q, valid_d;

    // Input path: sync chain then one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], osc_in};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign edge_pulse = sync_q[SYNC_STAGES-1] & ~dly_q;

    // Saturating increment; an attempted increment at max flags overflow.
    always_comb begin
        cnt_next = cnt_q;
        ovf_next = ovf_q;
        if (edge_pulse) begin
            if (cnt_q == CNT_MAX) begin
                ovf_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gate_d     = gate_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        valid_d    = valid_q;

        unique case (state_q)
            StIdle: begin
                if (start && en) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                cnt_d   = '0;
                ovf_d   = 1'b0;
                gate_d  = '0;
                state_d = StGate;
            end
            StGate: begin
                cnt_d  = cnt_next;
                ovf_d  = ovf_next;
                gate_d = gate_q + GATE_W'(1);
                // Final gate cycle: its own pulse is included in the published result.
                if (gate_q == GATE_LAST) begin
                    count_d    = cnt_next;
                    overflow_d = ovf_next;
                    valid_d    = 1'b1;
                    state_d    = StHold;
                end
            end
            StHold: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
                    state_d = continuous ? StArm : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Disable wins over everything; count_out is deliberately kept.
        if (!en) begin
            state_d    = StIdle;
            valid_d    = 1'b0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gate_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
        end
    end

    assign count_out = count_q;
    assign valid     = valid_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_stress_freq_meter.sv
// Bench for stress_freq_meter: scoreboard of expected results checked at each transfer,
// plus directed checks for hold-off, abort paths and counter saturation.
module tb_stress_freq_meter;

    localparam int GATE = 64;

    logic        clk = 1'b0;
    logic        rst_n, en, osc_in, start, continuous, ready;
    logic [15:0] count_out;
    logic        valid, overflow, busy;

    logic        osc2, start2, ready2;
    logic [3:0]  count2;
    logic        valid2, ovf2, busy2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int osc_half = 0;
    int ph = 0;

    typedef struct {
        int count;
        bit ovf;
        int due;
    } exp_t;

    exp_t sb_q[$];

    stress_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc_in), .start(start),
        .continuous(continuous), .ready(ready), .count_out(count_out),
        .valid(valid), .overflow(overflow), .busy(busy)
    );

    stress_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .en(en), .osc_in(osc2), .start(start2),
        .continuous(1'b0), .ready(ready2), .count_out(count2),
        .valid(valid2), .overflow(ovf2), .busy(busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle and queue nres expected results, one per window.
    task automatic do_start(input int ncount, input bit novf, input int nres);
        exp_t e;
        for (int i = 0; i < nres; i++) begin
            e.count = ncount;
            e.ovf   = novf;
            e.due   = cyc + (i + 1) * (GATE + 2);
            sb_q.push_back(e);
        end
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!valid && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check(tag, valid, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick(1);
            n++;
        end
        if (n >= budget) check(tag, busy, 0);
    endtask

    // Oscillator models: osc_in with programmable half period, osc2 at clk/2.
    initial begin
        osc_in = 1'b0;
        osc2   = 1'b0;
        forever begin
            @(negedge clk);
            osc2 = ~osc2;
            if (osc_half == 0) begin
                osc_in = 1'b0;
                ph     = 0;
            end else begin
                ph++;
                if (ph >= osc_half) begin
                    ph     = 0;
                    osc_in = ~osc_in;
                end
            end
        end
    end

    // Scoreboard monitor: latency on valid rise, result contents on each transfer.
    initial begin
        logic pv;
        exp_t e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (valid && !pv) begin
                if (sb_q.size() == 0) check("unexpected_valid", valid, 0);
                else check("latency", cyc, sb_q[0].due);
            end
            if (valid && ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_xfer", valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    check("count", count_out, e.count);
                    check("overflow", overflow, e.ovf);
                end
            end
            pv = valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int seen;
        int n;

        rst_n = 1'b0; en = 1'b1; start = 1'b0; continuous = 1'b0; ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b1;
        tick(3);
        check("rst_count", count_out, 0);
        check("rst_valid", valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;

        // Period 4, downstream stalls for 10 cycles.
        osc_half = 2;
        tick(10);
        do_start(16, 1'b0, 1);
        wait_valid("timeout_a", 200);
        repeat (10) begin
            check("hold_valid", valid, 1);
            check("hold_count", count_out, 16);
            tick(1);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        check("xfer_valid_low", valid, 0);
        check("xfer_busy_low", busy, 0);

        // Constant oscillator input.
        osc_half = 0;
        tick(10);
        ready = 1'b1;
        do_start(0, 1'b0, 1);
        wait_idle("timeout_b", 200);
        check("sb_drained_b", sb_q.size(), 0);

        // Period 8 with a second start mid-window that must be dropped.
        osc_half = 4;
        tick(10);
        do_start(8, 1'b0, 1);
        tick(20);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_idle("timeout_c", 200);
        tick(5);
        check("no_requeue_busy", busy, 0);
        check("sb_drained_c", sb_q.size(), 0);

        // Continuous mode, three back-to-back windows, cleared during the third.
        continuous = 1'b1;
        c0 = cyc;
        do_start(8, 1'b0, 3);
        while (cyc < c0 + 2 * (GATE + 2) + 20) tick(1);
        continuous = 1'b0;
        wait_idle("timeout_d", 300);
        check("sb_drained_d", sb_q.size(), 0);

        // en low mid-window aborts without a result; count_out is retained.
        do_start(0, 1'b0, 0);
        tick(20);
        en = 1'b0;
        tick(1);
        check("en_busy", busy, 0);
        check("en_valid", valid, 0);
        check("en_overflow", overflow, 0);
        check("en_count_kept", count_out, 8);
        en = 1'b1;
        seen = 0;
        repeat (80) begin
            tick(1);
            if (valid) seen++;
        end
        check("en_no_valid", seen, 0);

        // Reset at gate cycle 20.
        do_start(0, 1'b0, 0);
        tick(21);
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", count_out, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            tick(1);
            if (valid || busy) seen++;
        end
        check("rst_no_activity", seen, 0);

        // 4-bit counter at clk/2 must saturate and flag overflow.
        c0 = cyc;
        start2 = 1'b1;
        tick(1);
        start2 = 1'b0;
        n = 0;
        while (!valid2 && n < 200) begin
            tick(1);
            n++;
        end
        check("sat_latency", cyc, c0 + GATE + 2);
        check("sat_count", count2, 15);
        check("sat_overflow", ovf2, 1);
        tick(1);
        check("sat_idle", busy2, 0);

        tick(5);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
